tile_map: RTL and testbench

- Owns the 20x15 playfield tile map that the tank blocks read for movement checks.
- Consumes both players' tank and bullet tile coordinates once per frame.
- Resolves bullet impacts against walls, bricks and the opposing tank; writes brick damage back into the map; keeps scores.
- Sits between the two tank instances and the renderer, in the frame_clk domain.

---
 rtl/tile_map.sv | 170 +++++++++++++++++
 tb/tb_tile_map.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map.sv
// tile_map: owns the 20x15 playfield, resolves bullet impacts against walls, bricks and the
// opposing tank, writes brick damage back into the map and keeps both scores.
// Optional feature macro: BRICK_REGEN_EN (periodic rebuild of destroyed bricks).
module tile_map #(
   parameter int MAP_W        = 20,
   parameter int MAP_H        = 15,
   parameter int WIN_SCORE    = 5,
   parameter int REGEN_PERIOD = 600
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  int         TankX1,
   input  int         TankY1,
   input  int         TankX2,
   input  int         TankY2,
   input  int         BulX1,
   input  int         BulY1,
   input  int         BulX2,
   input  int         BulY2,
   output int         map [MAP_W*MAP_H],
   output logic       bul_hit1,
   output logic       bul_hit2,
   output logic       tank_hit1,
   output logic       tank_hit2,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       game_over
);

   localparam int NumTiles = MAP_W * MAP_H;
   localparam int IdxW     = $clog2(NumTiles);

   // A regen period below one frame can never wrap.
   if (REGEN_PERIOD < 1) begin : g_bad_regen_period
      $error("REGEN_PERIOD must be at least 1");
   end

   // Tile code at power-up: wall border, brick lattice, empty elsewhere.
   function automatic int reset_tile(input int i);
      int x, y;
      x = i % MAP_W;
      y = i / MAP_W;
      if (x == 0 || x == MAP_W - 1 || y == 0 || y == MAP_H - 1) return 1;
      if (x % 4 == 2 && y % 4 == 3) return 2;
      return 0;
   endfunction

   function automatic logic in_range(input int x, input int y);
      return x >= 0 && x < MAP_W && y >= 0 && y < MAP_H;
   endfunction

   int              map_q [NumTiles];
   int              map_d [NumTiles];
   logic [3:0]      score1_q, score1_d, score2_q, score2_d;
   logic            bh1_q, bh1_d, bh2_q, bh2_d, th1_q, th1_d, th2_q, th2_d;
   logic            go_q, go_d;
   logic            v1, v2, opp1, opp2, own1, own2;
   logic [IdxW-1:0] i1, i2;
   int              t1, t2;
`ifdef BRICK_REGEN_EN
   int              regen_q, regen_d;
   logic            tk1_v, tk2_v;
   logic [IdxW-1:0] tk1_i, tk2_i;
`endif

   // Next-state: impact resolution, scoring, game-over latch and optional brick regen.
   always_comb begin
      map_d    = map_q;
      score1_d = score1_q;
      score2_d = score2_q;
      bh1_d    = 1'b0;
      bh2_d    = 1'b0;
      th1_d    = 1'b0;
      th2_d    = 1'b0;
      go_d     = go_q;

      v1   = in_range(BulX1, BulY1);
      v2   = in_range(BulX2, BulY2);
      i1   = v1 ? IdxW'(BulY1 * MAP_W + BulX1) : '0;
      i2   = v2 ? IdxW'(BulY2 * MAP_W + BulX2) : '0;
      t1   = map_q[i1];
      t2   = map_q[i2];
      opp1 = v1 && BulX1 == TankX2 && BulY1 == TankY2;
      opp2 = v2 && BulX2 == TankX1 && BulY2 == TankY1;
      own1 = v1 && BulX1 == TankX1 && BulY1 == TankY1;
      own2 = v2 && BulX2 == TankX2 && BulY2 == TankY2;

      if (!go_q) begin
         if (opp1) begin
            bh1_d = 1'b1;
            th2_d = 1'b1;
            if (score1_q != 4'hf) score1_d = score1_q + 4'd1;
         end else if (v1 && !own1 && t1 != 0) begin
            bh1_d = 1'b1;
            if (t1 >= 2) map_d[i1] = (t1 == 2) ? 3 : 0;
         end
         // Both damage steps derive from map_q, so a shared brick only drops one step.
         if (opp2) begin
            bh2_d = 1'b1;
            th1_d = 1'b1;
            if (score2_q != 4'hf) score2_d = score2_q + 4'd1;
         end else if (v2 && !own2 && t2 != 0) begin
            bh2_d = 1'b1;
            if (t2 >= 2) map_d[i2] = (t2 == 2) ? 3 : 0;
         end
         go_d = (int'(score1_d) >= WIN_SCORE) || (int'(score2_d) >= WIN_SCORE);
      end

`ifdef BRICK_REGEN_EN
      regen_d = regen_q;
      tk1_v   = in_range(TankX1, TankY1);
      tk2_v   = in_range(TankX2, TankY2);
      tk1_i   = tk1_v ? IdxW'(TankY1 * MAP_W + TankX1) : '0;
      tk2_i   = tk2_v ? IdxW'(TankY2 * MAP_W + TankX2) : '0;
      if (!go_q) begin
         if (regen_q == REGEN_PERIOD - 1) begin
            regen_d = 0;
            // Applied after bullet damage so regen wins on a coincident edge.
            for (int i = 0; i < NumTiles; i++) begin
               if (reset_tile(i) == 2 && (map_d[i] == 0 || map_d[i] == 3) &&
                   !(tk1_v && tk1_i == IdxW'(i)) && !(tk2_v && tk2_i == IdxW'(i))) begin
                  map_d[i] = 2;
               end
            end
         end else begin
            regen_d = regen_q + 1;
         end
      end
`endif
   end

   // State registers; reset restores the power-up layout at once.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NumTiles; i++) map_q[i] <= reset_tile(i);
         score1_q <= '0;
         score2_q <= '0;
         bh1_q    <= 1'b0;
         bh2_q    <= 1'b0;
         th1_q    <= 1'b0;
         th2_q    <= 1'b0;
         go_q     <= 1'b0;
`ifdef BRICK_REGEN_EN
         regen_q  <= 0;
`endif
      end else begin
         map_q    <= map_d;
         score1_q <= score1_d;
         score2_q <= score2_d;
         bh1_q    <= bh1_d;
         bh2_q    <= bh2_d;
         th1_q    <= th1_d;
         th2_q    <= th2_d;
         go_q     <= go_d;
`ifdef BRICK_REGEN_EN
         regen_q  <= regen_d;
`endif
      end
   end

   assign map       = map_q;
   assign bul_hit1  = bh1_q;
   assign bul_hit2  = bh2_q;
   assign tank_hit1 = th1_q;
   assign tank_hit2 = th2_q;
   assign score1    = score1_q;
   assign score2    = score2_q;
   assign game_over = go_q;

endmodule

// File: tb/tb_tile_map.sv
// tb_tile_map: scoreboard bench for tile_map; expected per-frame results are queued as
// stimulus is driven and popped when the registered outputs appear.
module tb_tile_map;

   localparam int N = 300;

   logic       frame_clk = 1'b0;
   logic       Reset;
   int         TankX1, TankY1, TankX2, TankY2;
   int         BulX1, BulY1, BulX2, BulY2;
   int         map [N];
   logic       bul_hit1, bul_hit2, tank_hit1, tank_hit2, game_over;
   logic [3:0] score1, score2;

   int vecs = 0;
   int miss = 0;

   typedef struct {
      int          bx1, by1, bx2, by2, tx1, ty1, tx2, ty2;
      logic [12:0] flags;
      int          midx, mval;
   } step_t;

   step_t sb [$];

   always #5 frame_clk = ~frame_clk;

   tile_map #(.REGEN_PERIOD(4)) dut (
      .frame_clk(frame_clk), .Reset(Reset),
      .TankX1(TankX1), .TankY1(TankY1), .TankX2(TankX2), .TankY2(TankY2),
      .BulX1(BulX1), .BulY1(BulY1), .BulX2(BulX2), .BulY2(BulY2),
      .map(map), .bul_hit1(bul_hit1), .bul_hit2(bul_hit2),
      .tank_hit1(tank_hit1), .tank_hit2(tank_hit2),
      .score1(score1), .score2(score2), .game_over(game_over)
   );

   // {bul_hit1, bul_hit2, tank_hit1, tank_hit2, score1, score2, game_over}
   function automatic logic [12:0] fl(input bit bh1, input bit bh2, input bit th1,
                                      input bit th2, input int s1, input int s2, input bit go);
      return {bh1, bh2, th1, th2, 4'(s1), 4'(s2), go};
   endfunction

   // Step with both tanks on their spawn tiles.
   function automatic step_t mk(input int bx1, input int by1, input int bx2, input int by2,
                                input logic [12:0] f, input int midx, input int mval);
      step_t s;
      s = '{bx1: bx1, by1: by1, bx2: bx2, by2: by2, tx1: 1, ty1: 13, tx2: 18, ty2: 1,
            flags: f, midx: midx, mval: mval};
      return s;
   endfunction

   function automatic logic [12:0] obs();
      return {bul_hit1, bul_hit2, tank_hit1, tank_hit2, score1, score2, game_over};
   endfunction

   task automatic test_reset();
      int bricks, walls;
      TankX1 = 1;  TankY1 = 13; TankX2 = 18; TankY2 = 1;
      BulX1 = -1;  BulY1 = -1;  BulX2 = -1;  BulY2 = -1;
      Reset = 1'b1;
      repeat (2) @(posedge frame_clk);
      #1;
      vecs++; if (map[0] !== 1) begin miss++; $display("FAIL reset map[0] got %0d want 1", map[0]); end
      vecs++; if (map[62] !== 2) begin miss++; $display("FAIL reset map[62] got %0d want 2", map[62]); end
      vecs++; if (map[261] !== 0) begin miss++; $display("FAIL reset map[261] got %0d want 0", map[261]); end
      vecs++; if (map[38] !== 0) begin miss++; $display("FAIL reset map[38] got %0d want 0", map[38]); end
      vecs++;
      if (obs() !== 13'd0) begin miss++; $display("FAIL reset flags got %b want %b", obs(), 13'd0); end
      bricks = 0;
      walls  = 0;
      for (int i = 0; i < N; i++) begin
         if (map[i] == 2) bricks++;
         if (map[i] == 1) walls++;
      end
      vecs++; if (bricks !== 15) begin miss++; $display("FAIL reset bricks got %0d want 15", bricks); end
      vecs++; if (walls !== 66) begin miss++; $display("FAIL reset walls got %0d want 66", walls); end
      Reset = 1'b0;
   endtask

   task automatic test_brick_and_wall();
      step_t t [$];
      step_t e;
      t.push_back(mk(2, 3, -1, -1, fl(1, 0, 0, 0, 0, 0, 0), 62, 3));
      t.push_back(mk(2, 3, -1, -1, fl(1, 0, 0, 0, 0, 0, 0), 62, 0));
      t.push_back(mk(2, 3, -1, -1, fl(0, 0, 0, 0, 0, 0, 0), 62, 0));
      t.push_back(mk(-1, -1, 0, 5, fl(0, 1, 0, 0, 0, 0, 0), 100, 1));
      t.push_back(mk(-1, -1, -1, -1, fl(0, 0, 0, 0, 0, 0, 0), 100, 1));
      t.push_back(mk(1, 13, -1, -1, fl(0, 0, 0, 0, 0, 0, 0), 261, 0));
      t.push_back(mk(20, 3, -1, 15, fl(0, 0, 0, 0, 0, 0, 0), 79, 1));
      foreach (t[k]) begin
         BulX1 = t[k].bx1; BulY1 = t[k].by1; BulX2 = t[k].bx2; BulY2 = t[k].by2;
         TankX1 = t[k].tx1; TankY1 = t[k].ty1; TankX2 = t[k].tx2; TankY2 = t[k].ty2;
         sb.push_back(t[k]);
         @(posedge frame_clk);
         #1;
         e = sb.pop_front();
         vecs++;
         if (obs() !== e.flags) begin
            miss++; $display("FAIL brick_wall[%0d] flags got %b want %b", k, obs(), e.flags);
         end
         vecs++;
         if (map[e.midx] !== e.mval) begin
            miss++;
            $display("FAIL brick_wall[%0d] map[%0d] got %0d want %0d", k, e.midx, map[e.midx],
                     e.mval);
         end
      end
   endtask

   task automatic test_shared_and_tanks();
      step_t t [$];
      step_t e;
      t.push_back(mk(6, 7, 6, 7, fl(1, 1, 0, 0, 0, 0, 0), 146, 3));
      t.push_back(mk(4, 4, 4, 4, fl(0, 0, 0, 0, 0, 0, 0), 84, 0));
      t.push_back(mk(18, 1, 1, 13, fl(1, 1, 1, 1, 1, 1, 0), 146, 3));
      t.push_back(mk(-1, -1, -1, -1, fl(0, 0, 0, 0, 1, 1, 0), 38, 0));
      foreach (t[k]) begin
         BulX1 = t[k].bx1; BulY1 = t[k].by1; BulX2 = t[k].bx2; BulY2 = t[k].by2;
         TankX1 = t[k].tx1; TankY1 = t[k].ty1; TankX2 = t[k].tx2; TankY2 = t[k].ty2;
         sb.push_back(t[k]);
         @(posedge frame_clk);
         #1;
         e = sb.pop_front();
         vecs++;
         if (obs() !== e.flags) begin
            miss++; $display("FAIL shared_tanks[%0d] flags got %b want %b", k, obs(), e.flags);
         end
         vecs++;
         if (map[e.midx] !== e.mval) begin
            miss++;
            $display("FAIL shared_tanks[%0d] map[%0d] got %0d want %0d", k, e.midx,
                     map[e.midx], e.mval);
         end
      end
   endtask

   task automatic test_win();
      step_t t [$];
      step_t e;
      step_t s;
      // Asynchronous reset between edges must restore state without a clock.
      Reset = 1'b1;
      #2;
      vecs++; if (map[62] !== 2) begin miss++; $display("FAIL async_reset map[62] got %0d want 2", map[62]); end
      vecs++; if (map[146] !== 2) begin miss++; $display("FAIL async_reset map[146] got %0d want 2", map[146]); end
      vecs++;
      if (obs() !== 13'd0) begin miss++; $display("FAIL async_reset flags got %b want %b", obs(), 13'd0); end
      Reset = 1'b0;
      for (int h = 1; h <= 5; h++) begin
         s = mk(5, 5, -1, -1, fl(1, 0, 0, 1, h, 0, h >= 5), 105, 0);
         s.tx2 = 5; s.ty2 = 5;
         t.push_back(s);
         s = mk(-1, -1, -1, -1, fl(0, 0, 0, 0, h, 0, h >= 5), 105, 0);
         s.tx2 = 5; s.ty2 = 5;
         t.push_back(s);
      end
      t.push_back(mk(14, 3, 14, 3, fl(0, 0, 0, 0, 5, 0, 1), 74, 2));
      t.push_back(mk(18, 1, 1, 13, fl(0, 0, 0, 0, 5, 0, 1), 74, 2));
      foreach (t[k]) begin
         BulX1 = t[k].bx1; BulY1 = t[k].by1; BulX2 = t[k].bx2; BulY2 = t[k].by2;
         TankX1 = t[k].tx1; TankY1 = t[k].ty1; TankX2 = t[k].tx2; TankY2 = t[k].ty2;
         sb.push_back(t[k]);
         @(posedge frame_clk);
         #1;
         e = sb.pop_front();
         vecs++;
         if (obs() !== e.flags) begin
            miss++; $display("FAIL win[%0d] flags got %b want %b", k, obs(), e.flags);
         end
         vecs++;
         if (map[e.midx] !== e.mval) begin
            miss++;
            $display("FAIL win[%0d] map[%0d] got %0d want %0d", k, e.midx, map[e.midx], e.mval);
         end
      end
   endtask

   task automatic test_regen();
      step_t t [$];
      step_t e;
      step_t s;
      Reset = 1'b1;
      #2;
      vecs++;
      if (game_over !== 1'b0) begin miss++; $display("FAIL regen_reset game_over got %b want 0", game_over); end
      Reset = 1'b0;
      t.push_back(mk(10, 11, -1, -1, fl(1, 0, 0, 0, 0, 0, 0), 230, 3));
      t.push_back(mk(10, 11, -1, -1, fl(1, 0, 0, 0, 0, 0, 0), 230, 0));
`ifdef BRICK_REGEN_EN
      t.push_back(mk(-1, -1, -1, -1, fl(0, 0, 0, 0, 0, 0, 0), 230, 0));
      t.push_back(mk(-1, -1, -1, -1, fl(0, 0, 0, 0, 0, 0, 0), 230, 2));
      t.push_back(mk(10, 11, -1, -1, fl(1, 0, 0, 0, 0, 0, 0), 230, 3));
      t.push_back(mk(10, 11, -1, -1, fl(1, 0, 0, 0, 0, 0, 0), 230, 0));
      for (int f = 0; f < 2; f++) begin
         s = mk(-1, -1, -1, -1, fl(0, 0, 0, 0, 0, 0, 0), 230, 0);
         s.tx1 = 10; s.ty1 = 11;
         t.push_back(s);
      end
      for (int f = 0; f < 3; f++) t.push_back(mk(-1, -1, -1, -1, fl(0, 0, 0, 0, 0, 0, 0), 230, 0));
      t.push_back(mk(-1, -1, -1, -1, fl(0, 0, 0, 0, 0, 0, 0), 230, 2));
`else
      for (int f = 0; f < 10; f++) t.push_back(mk(-1, -1, -1, -1, fl(0, 0, 0, 0, 0, 0, 0), 230, 0));
`endif
      foreach (t[k]) begin
         BulX1 = t[k].bx1; BulY1 = t[k].by1; BulX2 = t[k].bx2; BulY2 = t[k].by2;
         TankX1 = t[k].tx1; TankY1 = t[k].ty1; TankX2 = t[k].tx2; TankY2 = t[k].ty2;
         sb.push_back(t[k]);
         @(posedge frame_clk);
         #1;
         e = sb.pop_front();
         vecs++;
         if (obs() !== e.flags) begin
            miss++; $display("FAIL regen[%0d] flags got %b want %b", k, obs(), e.flags);
         end
         vecs++;
         if (map[e.midx] !== e.mval) begin
            miss++;
            $display("FAIL regen[%0d] map[%0d] got %0d want %0d", k, e.midx, map[e.midx], e.mval);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_brick_and_wall();
      test_shared_and_tanks();
      test_win();
      test_regen();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
